// File: rtl/fsub_shell_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fsub_shell_pkg
//  Brief    : Shared FPU constants and float32 classification helper used by
//             the fsub_p2 core and its valid/ready shell.
//  Revision : 1.0 - initial release
// ============================================================================
package fsub_shell_pkg;

  // float32 field constants
  localparam logic [7:0]  c_f32_exp_ones = 8'hFF;
  localparam logic [31:0] c_f32_qnan     = 32'hFFC00000;
  localparam logic [31:0] c_f32_pinf     = 32'h7F800000;

  // Operand-to-result latency of fsub_p2, in clock edges
  localparam int c_fsub_p2_lat = 2;

  typedef enum logic [1:0] {
    F32_ZERO = 2'd0,   // zero or denormal (denormals are flushed)
    F32_NORM = 2'd1,
    F32_INF  = 2'd2,
    F32_NAN  = 2'd3
  } f32_class_e;

  function automatic f32_class_e f32_class(input logic [31:0] v);
    if (v[30:23] == c_f32_exp_ones) return (v[22:0] != 23'd0) ? F32_NAN : F32_INF;
    if (v[30:23] == 8'h00) return F32_ZERO;
    return F32_NORM;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fsub_p2.sv
`default_nettype none
// ============================================================================
//  Module   : fsub_p2
//  Brief    : Free-running two-stage float32 subtractor, y = x1 - x2.
//             Round-to-nearest-even, denormals flushed to zero, any NaN or
//             Inf-Inf gives the canonical quiet NaN. ovf flags a finite
//             difference that rounded up to infinity.
//  Revision : 1.0 - initial release
// ============================================================================
module fsub_p2 import fsub_shell_pkg::*; (
  input  logic        clk,
  input  logic        rstn,
  input  logic [31:0] x1,
  input  logic [31:0] x2,
  output logic [31:0] y,
  output logic        ovf
);

  // ---------------- stage 1: classify, order by magnitude, align ----------
  f32_class_e  w_c1, w_c2;
  logic        w_s1, w_s2, w_swap, w_sa, w_sb;
  logic [30:0] w_mag1, w_mag2;
  logic [7:0]  w_ea, w_eb, w_d;
  logic [22:0] w_fa, w_fb;
  logic [23:0] w_ma, w_mb;
  logic [4:0]  w_dc;
  logic [53:0] w_shift;
  logic [26:0] w_mb_al;
  logic        w_special;
  logic [31:0] w_special_y;

  logic        r_sa, r_sub, r_special, r_zboth, r_zsign;
  logic [7:0]  r_ea;
  logic [26:0] r_ma, r_mb;
  logic [31:0] r_special_y;

  // Unpack operands (x2 sign inverted: subtraction is addition of -x2) and align the smaller one
  always_comb begin
    w_c1   = f32_class(x1);
    w_c2   = f32_class(x2);
    w_s1   = x1[31];
    w_s2   = ~x2[31];
    w_mag1 = x1[30:0];
    w_mag2 = x2[30:0];
    w_swap = (w_mag2 > w_mag1);
    w_sa   = w_swap ? w_s2 : w_s1;
    w_sb   = w_swap ? w_s1 : w_s2;
    w_ea   = w_swap ? w_mag2[30:23] : w_mag1[30:23];
    w_eb   = w_swap ? w_mag1[30:23] : w_mag2[30:23];
    w_fa   = w_swap ? w_mag2[22:0]  : w_mag1[22:0];
    w_fb   = w_swap ? w_mag1[22:0]  : w_mag2[22:0];
    w_ma   = (w_ea == 8'h00) ? 24'd0 : {1'b1, w_fa};
    w_mb   = (w_eb == 8'h00) ? 24'd0 : {1'b1, w_fb};
    // Shifts past the guard/round/sticky window only feed the sticky bit
    w_d     = w_ea - w_eb;
    w_dc    = (w_d > 8'd26) ? 5'd27 : w_d[4:0];
    w_shift = {w_mb, 3'b000, 27'd0} >> w_dc;
    w_mb_al = {w_shift[53:28], w_shift[27] | (|w_shift[26:0])};

    w_special   = 1'b0;
    w_special_y = c_f32_qnan;
    if (w_c1 == F32_NAN || w_c2 == F32_NAN) begin
      w_special = 1'b1;
    end else if (w_c1 == F32_INF && w_c2 == F32_INF) begin
      w_special   = 1'b1;
      w_special_y = (w_s1 == w_s2) ? {w_s1, c_f32_pinf[30:0]} : c_f32_qnan;
    end else if (w_c1 == F32_INF) begin
      w_special   = 1'b1;
      w_special_y = {w_s1, c_f32_pinf[30:0]};
    end else if (w_c2 == F32_INF) begin
      w_special   = 1'b1;
      w_special_y = {w_s2, c_f32_pinf[30:0]};
    end
  end

  // Stage-1 pipeline register
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_sa        <= 1'b0;
      r_sub       <= 1'b0;
      r_ea        <= 8'd0;
      r_ma        <= 27'd0;
      r_mb        <= 27'd0;
      r_special   <= 1'b0;
      r_special_y <= 32'd0;
      r_zboth     <= 1'b0;
      r_zsign     <= 1'b0;
    end else begin
      r_sa        <= w_sa;
      r_sub       <= w_sa ^ w_sb;
      r_ea        <= w_ea;
      r_ma        <= {w_ma, 3'b000};
      r_mb        <= w_mb_al;
      r_special   <= w_special;
      r_special_y <= w_special_y;
      r_zboth     <= (w_c1 == F32_ZERO) && (w_c2 == F32_ZERO);
      r_zsign     <= w_s1 & w_s2;
    end
  end

  // ---------------- stage 2: add, normalise, round, pack ------------------
  logic [27:0] w_sum;
  logic [26:0] w_norm;
  logic [4:0]  w_lz;
  logic        w_found, w_rnd;
  logic [10:0] w_exp, w_exp2;
  logic [24:0] w_mr;
  logic [22:0] w_mant;
  logic [31:0] w_y;
  logic        w_ovf;

  // Magnitude add/subtract, normalise to a leading one at bit 26, then RNE
  always_comb begin
    w_sum   = r_sub ? ({1'b0, r_ma} - {1'b0, r_mb}) : ({1'b0, r_ma} + {1'b0, r_mb});
    w_lz    = 5'd0;
    w_found = 1'b0;
    for (int i = 0; i < 27; i++) begin
      if (!w_found && w_sum[26-i]) begin
        w_lz    = 5'(i);
        w_found = 1'b1;
      end
    end
    if (w_sum[27]) begin
      w_norm = {w_sum[27:2], w_sum[1] | w_sum[0]};
      w_exp  = {3'b000, r_ea} + 11'd1;
    end else begin
      w_norm = w_sum[26:0] << w_lz;
      w_exp  = {3'b000, r_ea} - {6'd0, w_lz};
    end
    w_rnd  = w_norm[2] & (w_norm[1] | w_norm[0] | w_norm[3]);
    w_mr   = {1'b0, w_norm[26:3]} + {24'd0, w_rnd};
    // A rounding carry out leaves mantissa 1.000..0 one binade up
    w_mant = w_mr[24] ? 23'd0 : w_mr[22:0];
    w_exp2 = w_exp + {10'd0, w_mr[24]};

    w_ovf = 1'b0;
    if (r_special) begin
      w_y = r_special_y;
    end else if (w_sum == 28'd0) begin
      w_y = {r_zboth & r_zsign, 31'd0};
    end else if (w_exp2[10] || w_exp2 == 11'd0) begin
      w_y = {r_sa, 31'd0};
    end else if (w_exp2 >= 11'd255) begin
      w_y   = {r_sa, c_f32_pinf[30:0]};
      w_ovf = 1'b1;
    end else begin
      w_y = {r_sa, w_exp2[7:0], w_mant};
    end
  end

  // Stage-2 (output) register
  always_ff @(posedge clk) begin
    if (!rstn) begin
      y   <= 32'd0;
      ovf <= 1'b0;
    end else begin
      y   <= w_y;
      ovf <= w_ovf;
    end
  end

endmodule
`default_nettype wire

// File: rtl/fsub_shell_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : fsub_shell_fifo
//  Brief    : Circular result FIFO with wrap-bit pointers and an occupancy
//             counter. Pops while empty are ignored.
//  Revision : 1.0 - initial release
// ============================================================================
module fsub_shell_fifo #(
  parameter int WIDTH = 37,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int c_aw = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [c_aw:0]    r_wr, r_rd, r_count;
  logic             w_pop;

  // Advance a pointer, toggling the wrap bit when the index passes DEPTH-1
  function automatic logic [c_aw:0] f_next(input logic [c_aw:0] p);
    if (p[c_aw-1:0] == c_aw'(DEPTH-1)) return {~p[c_aw], {c_aw{1'b0}}};
    return p + (c_aw+1)'(1);
  endfunction

  assign count = r_count;
  assign full  = (r_count == (c_aw+1)'(DEPTH));
  assign empty = (r_count == '0);
  assign w_pop = pop && !empty;
  assign dout  = r_mem[r_rd[c_aw-1:0]];

  // Pointer and occupancy update
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (push)  r_wr <= f_next(r_wr);
      if (w_pop) r_rd <= f_next(r_rd);
      case ({push, w_pop})
        2'b10:   r_count <= r_count + (c_aw+1)'(1);
        2'b01:   r_count <= r_count - (c_aw+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage write; contents need no reset since count gates visibility
  always_ff @(posedge clk) begin
    if (push) r_mem[r_wr[c_aw-1:0]] <= din;
  end

  // Upstream credit accounting must make a full-FIFO push impossible
  always_ff @(posedge clk) begin
    if (rstn) begin
      a_no_push_when_full: assert (!(push && full));
    end
  end

endmodule
`default_nettype wire

// File: rtl/fsub_shell.sv
`default_nettype none
// ============================================================================
//  Module   : fsub_shell
//  Brief    : Valid/ready wrapper around fsub_p2. Tags accepted requests,
//             tracks them through the fixed core latency and captures the
//             results into a credit-protected output FIFO.
//  Revision : 1.0 - initial release
// ============================================================================
module fsub_shell import fsub_shell_pkg::*; #(
  parameter int LAT   = c_fsub_p2_lat,
  parameter int DEPTH = 4,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_x1,
  input  logic [31:0]      in_x2,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_y,
  output logic             out_ovf,
  output logic [TAG_W-1:0] out_tag,
  output logic             ovf_sticky,
  input  logic             ovf_clr,
  output logic             busy
);

  localparam int c_cw = $clog2(DEPTH) + 1;
  localparam int c_ew = 33 + TAG_W;

  logic [31:0]      w_core_y;
  logic             w_core_ovf;
  logic             w_accept, w_push, w_full, w_empty;
  logic [c_cw-1:0]  w_count, w_inflight;
  logic [c_cw:0]    w_used;
  logic [c_ew-1:0]  w_head;
  logic [LAT-1:0]   r_trk_vld;
  logic [TAG_W-1:0] r_trk_tag [LAT];
  logic             r_sticky;

  // The core computes every cycle; only tracked results are kept
  fsub_p2 u_core (
    .clk  (clk),
    .rstn (rstn),
    .x1   (in_x1),
    .x2   (in_x2),
    .y    (w_core_y),
    .ovf  (w_core_ovf)
  );

  // Credits: registered in-flight plus buffered entries; same-cycle pops give none back
  always_comb begin
    w_inflight = '0;
    for (int i = 0; i < LAT; i++) w_inflight = w_inflight + c_cw'(r_trk_vld[i]);
    w_used   = {1'b0, w_inflight} + {1'b0, w_count};
    in_ready = rstn && !w_full && (w_used < (c_cw+1)'(DEPTH));
    w_accept = in_valid && in_ready;
  end

  // Tracker shift register, aligned so the last stage matches core output timing
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_trk_vld <= '0;
      for (int i = 0; i < LAT; i++) r_trk_tag[i] <= '0;
    end else begin
      r_trk_vld[0] <= w_accept;
      r_trk_tag[0] <= in_tag;
      for (int i = 1; i < LAT; i++) begin
        r_trk_vld[i] <= r_trk_vld[i-1];
        r_trk_tag[i] <= r_trk_tag[i-1];
      end
    end
  end

  assign w_push = r_trk_vld[LAT-1];

  fsub_shell_fifo #(
    .WIDTH (c_ew),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (w_push),
    .din   ({w_core_y, w_core_ovf, r_trk_tag[LAT-1]}),
    .pop   (out_valid && out_ready),
    .dout  (w_head),
    .count (w_count),
    .full  (w_full),
    .empty (w_empty)
  );

  // Sticky overflow: a captured overflow beats a simultaneous clear
  always_ff @(posedge clk) begin
    if (!rstn)                     r_sticky <= 1'b0;
    else if (w_push && w_core_ovf) r_sticky <= 1'b1;
    else if (ovf_clr)              r_sticky <= 1'b0;
  end

  // Head presentation, forced to zero whenever nothing valid is held or in reset
  always_comb begin
    out_valid  = rstn && !w_empty;
    out_y      = out_valid ? w_head[c_ew-1:TAG_W+1] : 32'd0;
    out_ovf    = out_valid ? w_head[TAG_W]           : 1'b0;
    out_tag    = out_valid ? w_head[TAG_W-1:0]       : '0;
    ovf_sticky = rstn && r_sticky;
    busy       = rstn && ((w_inflight != '0) || !w_empty);
  end

endmodule
`default_nettype wire
